// File: rtl/bias_loader_mb.sv
// bias_loader_mb: loads one instruction's worth of DRAM beats into any subset of buffer banks.
//
// Ports:
//   kernel_clk, kernel_rst_n        clock, synchronous active-low reset
//   ap_start / ap_done / ap_busy    controller handshake (ap_done is a one-cycle pulse)
//   err                             sticky: [0] early tlast, [1] beats after the final beat
//   ctrl_addr_offset                DRAM base address
//   ctrl_instruction                [47:32] buffer start, [63:48] beat count, [79:64] DRAM start,
//                                   [95:80] byte length, [96 +: NUM_BANKS] bank mask
//   rd_start / rd_addr / rd_size    read-master request, rd_done its completion pulse
//   s_tvalid / s_tready / s_tdata / s_tlast   beat stream from the read master
//   buf_wr_valid / buf_wr_addr / buf_wr_data  per-bank enables, shared address and data
module bias_loader_mb #(
    parameter int INST_LENGTH        = 128,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int BUF_ADDR_WIDTH     = 9,
    parameter int NUM_BANKS          = 4
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_busy,
    output logic [1:0]                    err,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [INST_LENGTH-1:0]        ctrl_instruction,
    output logic                          rd_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]  rd_size,
    input  logic                          rd_done,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_tdata,
    input  logic                          s_tlast,
    output logic [NUM_BANKS-1:0]          buf_wr_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     buf_wr_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]                    r_state;
    logic [BUF_ADDR_WIDTH-1:0]     r_buf_start;
    logic [15:0]                   r_n;
    logic [15:0]                   r_k;
    logic [NUM_BANKS-1:0]          r_mask;
    logic                          r_seen;
    logic [1:0]                    r_err;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_rd_size;
    logic [NUM_BANKS-1:0]          r_wr_valid;
    logic [BUF_ADDR_WIDTH-1:0]     r_wr_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wr_data;
    logic                          w_last;
    logic                          w_unused;

    assign w_last       = r_k == r_n - 16'd1;
    // Only some instruction bits are fields; the rest are deliberately ignored.
    assign w_unused     = ^ctrl_instruction;
    assign ap_busy      = r_state != S_IDLE;
    assign ap_done      = r_state == S_FINISH;
    assign rd_start     = r_state == S_ISSUE;
    // Ready is purely state-based so the stream never sees a combinational loop.
    assign s_tready     = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign err          = r_err;
    assign rd_addr      = r_rd_addr;
    assign rd_size      = r_rd_size;
    assign buf_wr_valid = r_wr_valid;
    assign buf_wr_addr  = r_wr_addr;
    assign buf_wr_data  = r_wr_data;

    always_ff @(posedge kernel_clk) begin
        if (!kernel_rst_n) begin
            r_state     <= S_IDLE;
            r_buf_start <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_mask      <= '0;
            r_seen      <= 1'b0;
            r_err       <= '0;
            r_rd_addr   <= '0;
            r_rd_size   <= '0;
            r_wr_valid  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_buf_start <= ctrl_instruction[32 +: BUF_ADDR_WIDTH];
                        r_n         <= ctrl_instruction[63:48];
                        r_mask      <= ctrl_instruction[96 +: NUM_BANKS];
                        r_rd_addr   <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:64]);
                        r_rd_size   <= C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
                        r_k         <= '0;
                        r_seen      <= 1'b0;
                        r_err       <= '0;
                        r_state     <= ctrl_instruction[63:48] == 16'd0 ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_seen  <= r_seen | rd_done;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    r_seen <= r_seen | rd_done;
                    if (s_tvalid) begin
                        r_wr_valid <= r_mask;
                        r_wr_addr  <= r_buf_start + r_k[BUF_ADDR_WIDTH-1:0];
                        r_wr_data  <= s_tdata;
                        r_k        <= r_k + 16'd1;
                        if (s_tlast && !w_last) r_err[0] <= 1'b1;
                        if (w_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Beats here are surplus: swallow them and flag the overrun.
                    if (s_tvalid) r_err[1] <= 1'b1;
                    r_seen <= r_seen | rd_done;
                    if (r_seen || rd_done) r_state <= S_FINISH;
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule
